id_ex_pipe: RTL

- Decode-to-execute pipeline register of the 5-stage CPU. Sits directly downstream of the register file.
- Captures the register file read buses (busX/busY) with the decoded instruction fields, and owns load-use hazard detection.
- Inserts bubbles on load-use hazards and branch flushes, and freezes on L2/L1 memory stalls.
- Keeps saturating event counters for bubbles and flushes.

---
 rtl/id_ex_pipe_if.sv | 43 ++++
 rtl/id_ex_pipe.sv | 102 ++++++++++
 2 files changed

// File: rtl/id_ex_pipe_if.sv
// ID->EX bundle: decoded fields entering the stage and registered fields leaving it.
// master = upstream/ID side, slave = the pipeline register.
interface id_ex_pipe_if #(
  parameter int unsigned CTRLW = 8
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [31:0]      id_busX;
  logic [31:0]      id_busY;
  logic [31:0]      id_imm;
  logic             id_mem_read;
  logic             id_reg_write;
  logic [CTRLW-1:0] id_ctrl;

  logic             ex_valid;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic [31:0]      ex_busX;
  logic [31:0]      ex_busY;
  logic [31:0]      ex_imm;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [CTRLW-1:0] ex_ctrl;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
           id_busX, id_busY, id_imm, id_mem_read, id_reg_write, id_ctrl,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_busX, ex_busY, ex_imm,
           ex_mem_read, ex_reg_write, ex_ctrl
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
           id_busX, id_busY, id_imm, id_mem_read, id_reg_write, id_ctrl,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_busX, ex_busY, ex_imm,
           ex_mem_read, ex_reg_write, ex_ctrl
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard/flush, memory-stall freeze and saturating bubble/flush counters.
module id_ex_pipe #(
  parameter int unsigned CTRLW = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic            Clk,
  input  logic            rst,
  input  logic            stall_mem,
  input  logic            flush,
  id_ex_pipe_if.slave     bus,
  output logic            load_use_stall,
  output logic [CNTW-1:0] lu_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  logic             ex_valid_q;
  logic [4:0]       ex_rs_q;
  logic [4:0]       ex_rt_q;
  logic [4:0]       ex_rd_q;
  logic [31:0]      ex_busX_q;
  logic [31:0]      ex_busY_q;
  logic [31:0]      ex_imm_q;
  logic             ex_mem_read_q;
  logic             ex_reg_write_q;
  logic [CTRLW-1:0] ex_ctrl_q;
  logic [CNTW-1:0]  lu_cnt_q;
  logic [CNTW-1:0]  flush_cnt_q;

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = bus.id_use_rs && (bus.id_rs == ex_rd_q);
    rt_hit = bus.id_use_rt && (bus.id_rt == ex_rd_q);
    // Flush masks the hazard so a killed instruction never counts as a bubble.
    load_use_stall = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                     bus.id_valid && !flush && (rs_hit || rt_hit);
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_busX_q      <= '0;
      ex_busY_q      <= '0;
      ex_imm_q       <= '0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_ctrl_q      <= '0;
      lu_cnt_q       <= '0;
      flush_cnt_q    <= '0;
    end else if (!stall_mem) begin
      if (flush || load_use_stall) begin
        ex_valid_q     <= 1'b0;
        ex_rs_q        <= '0;
        ex_rt_q        <= '0;
        ex_rd_q        <= '0;
        ex_busX_q      <= '0;
        ex_busY_q      <= '0;
        ex_imm_q       <= '0;
        ex_mem_read_q  <= 1'b0;
        ex_reg_write_q <= 1'b0;
        ex_ctrl_q      <= '0;
      end else begin
        ex_valid_q     <= bus.id_valid;
        ex_rs_q        <= bus.id_rs;
        ex_rt_q        <= bus.id_rt;
        ex_rd_q        <= bus.id_rd;
        ex_busX_q      <= bus.id_busX;
        ex_busY_q      <= bus.id_busY;
        ex_imm_q       <= bus.id_imm;
        ex_mem_read_q  <= bus.id_mem_read && bus.id_valid;
        ex_reg_write_q <= bus.id_reg_write && bus.id_valid;
        ex_ctrl_q      <= bus.id_ctrl;
      end

      if (flush && bus.id_valid && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if (load_use_stall && (lu_cnt_q != '1)) begin
        lu_cnt_q <= lu_cnt_q + 1'b1;
      end
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_rs        = ex_rs_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_busX      = ex_busX_q;
  assign bus.ex_busY      = ex_busY_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_mem_read  = ex_mem_read_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign lu_cnt           = lu_cnt_q;
  assign flush_cnt        = flush_cnt_q;

endmodule
